// File: rtl/alu_ctrl_pkg.sv
// Shared types and widths for the ALU request arbiter: FSM states, operand
// bundle and the packing order of the captured ALU flags.
package alu_ctrl_pkg;

    localparam int OP_W   = 3;
    localparam int DATA_W = 4;
    localparam int FLAG_W = 4;

    localparam int FLAG_ZERO = 0;
    localparam int FLAG_CIN  = 1;
    localparam int FLAG_OVF  = 2;
    localparam int FLAG_CMP  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_req_t;

    function automatic logic [FLAG_W-1:0] pack_flags(
        input logic zero,
        input logic cin,
        input logic ovf,
        input logic cmp
    );
        logic [FLAG_W-1:0] f;
        f            = '0;
        f[FLAG_ZERO] = zero;
        f[FLAG_CIN]  = cin;
        f[FLAG_OVF]  = ovf;
        f[FLAG_CMP]  = cmp;
        return f;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin grant, purely combinational. When both inputs are
// valid the pointer picks the winner; the pointer register lives in the parent.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant,
    output logic       grant_idx
);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_grant
            assign grant[gi] = valid[gi] && (!valid[1-gi] || (ptr == 1'(gi)));
        end
    endgenerate

    assign grant_idx = grant[1];

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one ALU between two requesters: round-robin accept, registered ALU
// operands, fixed-latency capture, response handshake. Define ALU_ARB_STATS_EN
// to add saturating per-requester grant counters (grant_cnt0/grant_cnt1).
module alu_req_arbiter
    import alu_ctrl_pkg::*;
#(
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [OP_W-1:0]   req0_op,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [OP_W-1:0]   req1_op,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic [OP_W-1:0]   alu_select,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_cin,
    input  logic              alu_overflow,
    input  logic              alu_compare,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_result,
`ifdef ALU_ARB_STATS_EN
    output logic [7:0]        grant_cnt0,
    output logic [7:0]        grant_cnt1,
`endif
    output logic [FLAG_W-1:0] rsp_flags
);

    localparam logic [1:0] LAT_C = 2'(ALU_LAT);

    state_t            state_q, state_d;
    alu_req_t          req_q, req_d;
    logic              rr_ptr_q, rr_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic [FLAG_W-1:0] rsp_flags_q, rsp_flags_d;
    logic [1:0]        arb_valid, grant;
    logic              grant_idx, accept, lat_done;
    alu_req_t          req_in [2];

    assign req_in[0] = {req0_op, req0_a, req0_b};
    assign req_in[1] = {req1_op, req1_a, req1_b};

    // Requests are only visible to the arbiter in IDLE and outside reset, so
    // ready can never rise while busy or while rst is asserted.
    assign arb_valid = {req1_valid, req0_valid} & {2{(state_q == IDLE) && !rst}};
    assign accept    = |grant;
    assign lat_done  = (state_q == EXEC) && (cnt_q == LAT_C);

    rr_arb2 u_arb (
        .valid     (arb_valid),
        .ptr       (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = EXEC;
            EXEC:    if (lat_done)  state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready = grant[0];
        req1_ready = grant[1];
        rsp_valid  = (state_q == RESP);
    end

    always_comb begin
        req_d        = req_q;
        rr_ptr_d     = rr_ptr_q;
        cnt_d        = cnt_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_flags_d  = rsp_flags_q;
        if (accept) begin
            req_d    = req_in[grant_idx];
            rsp_id_d = grant_idx;
            rr_ptr_d = ~grant_idx;
            cnt_d    = 2'd0;
        end else if (state_q == EXEC) begin
            if (lat_done) begin
                rsp_result_d = alu_result;
                rsp_flags_d  = pack_flags(alu_zero, alu_cin, alu_overflow, alu_compare);
                cnt_d        = 2'd0;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q        <= '0;
            rr_ptr_q     <= 1'b0;
            cnt_q        <= 2'd0;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_flags_q  <= '0;
        end else begin
            req_q        <= req_d;
            rr_ptr_q     <= rr_ptr_d;
            cnt_q        <= cnt_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_flags_q  <= rsp_flags_d;
        end
    end

    assign alu_select = req_q.op;
    assign alu_a      = req_q.a;
    assign alu_b      = req_q.b;
    assign rsp_id     = rsp_id_q;
    assign rsp_result = rsp_result_q;
    assign rsp_flags  = rsp_flags_q;

`ifdef ALU_ARB_STATS_EN
    logic [7:0] grant_cnt_q [2];
    logic [7:0] grant_cnt_d [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_stats
            always_comb begin
                grant_cnt_d[gi] = grant_cnt_q[gi];
                if (grant[gi] && (grant_cnt_q[gi] != 8'hFF)) begin
                    grant_cnt_d[gi] = grant_cnt_q[gi] + 8'd1;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    grant_cnt_q[gi] <= 8'd0;
                end else begin
                    grant_cnt_q[gi] <= grant_cnt_d[gi];
                end
            end
        end
    endgenerate

    assign grant_cnt0 = grant_cnt_q[0];
    assign grant_cnt1 = grant_cnt_q[1];
`endif

endmodule
